// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Digit slices of the packed {H1,H0,M1,M0,S1,S0} time word
    localparam int H1_MSB = 23;
    localparam int H1_LSB = 20;
    localparam int H0_MSB = 19;
    localparam int H0_LSB = 16;
    localparam int M1_MSB = 15;
    localparam int M1_LSB = 12;
    localparam int M0_MSB = 11;
    localparam int M0_LSB = 8;
    localparam int S1_MSB = 7;
    localparam int S1_LSB = 4;
    localparam int S0_MSB = 3;
    localparam int S0_LSB = 0;

    localparam int SEC_TENS_MAX = 5;
    localparam int MIN_TENS_MAX = 5;
    localparam int HOUR_MAX     = 23;
    localparam int DIGIT_MAX    = 9;

endpackage

// File: rtl/bcd_time_dec.sv
// Combinational one-second decrement of a packed BCD HH:MM:SS value.
module bcd_time_dec
    import timer_pkg::*;
(
    input  logic [23:0] time_in,
    output logic [23:0] time_dec
);

    // Ripple a borrow from S0 upward; a zero digit wraps to its max and keeps borrowing.
    // H1 never wraps: the caller only decrements nonzero values.
    always_comb begin
        logic       borrow;
        logic [3:0] dig;
        logic [3:0] dmax;
        time_dec = time_in;
        borrow   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dig  = time_in[4*i +: 4];
            dmax = (i == 1) ? 4'(SEC_TENS_MAX) :
                   (i == 3) ? 4'(MIN_TENS_MAX) : 4'(DIGIT_MAX);
            if (borrow) begin
                if (dig == 4'd0 && i < 5) begin
                    time_dec[4*i +: 4] = dmax;
                end else begin
                    time_dec[4*i +: 4] = dig - 4'd1;
                    borrow             = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Nap countdown timer: loads a BCD HH:MM:SS value and counts it down once per second.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int PRE_W    = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [23:0] load_time,
    input  logic        start,
    input  logic        pause,
    output logic [23:0] time_out,
    output logic [1:0]  state,
    output logic        running,
    output logic        expired,
    output logic        load_err
);

    state_e             state_q, state_d;
    logic [23:0]        time_q, time_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic               running_q, running_d;
    logic               expired_q, expired_d;
    logic               load_err_q, load_err_d;

    logic [23:0]        time_dec;
    logic               load_ok;
    logic               tick;
    logic               dec_zero;
    logic               time_nz;

    bcd_time_dec u_dec (
        .time_in  (time_q),
        .time_dec (time_dec)
    );

    // Load validation: every digit decimal, tens of minutes/seconds <= 5, hours <= 23
    always_comb begin
        logic [3:0] h1, h0, m1, m0, s1, s0;
        logic [7:0] hh;
        h1 = load_time[H1_MSB:H1_LSB];
        h0 = load_time[H0_MSB:H0_LSB];
        m1 = load_time[M1_MSB:M1_LSB];
        m0 = load_time[M0_MSB:M0_LSB];
        s1 = load_time[S1_MSB:S1_LSB];
        s0 = load_time[S0_MSB:S0_LSB];
        hh = {4'd0, h1} * 8'd10 + {4'd0, h0};
        load_ok = (h1 <= 4'(DIGIT_MAX)) && (h0 <= 4'(DIGIT_MAX)) &&
                  (m1 <= 4'(MIN_TENS_MAX)) && (m0 <= 4'(DIGIT_MAX)) &&
                  (s1 <= 4'(SEC_TENS_MAX)) && (s0 <= 4'(DIGIT_MAX)) &&
                  (hh <= 8'(HOUR_MAX));
    end

    assign tick     = (pre_q == PRE_W'(TICK_DIV - 1));
    assign dec_zero = (time_dec == 24'd0);
    assign time_nz  = (time_q != 24'd0);

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            time_q     <= 24'd0;
            pre_q      <= '0;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            pre_q      <= pre_d;
            running_q  <= running_d;
            expired_q  <= expired_d;
            load_err_q <= load_err_d;
        end
    end

    // Next state: load dominates, then start/pause, then the final tick
    always_comb begin
        state_d = state_q;
        if (load) begin
            if (load_ok) state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (start && time_nz) state_d = ST_RUN;
                ST_RUN: begin
                    if (pause)                state_d = ST_PAUSE;
                    else if (tick && dec_zero) state_d = ST_DONE;
                end
                ST_PAUSE: if (start) state_d = ST_RUN;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath and pulse outputs; a pause in RUN freezes the prescaler so the partial second survives
    always_comb begin
        time_d     = time_q;
        pre_d      = pre_q;
        expired_d  = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_ok) begin
                time_d = load_time;
                pre_d  = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: if (start && time_nz) pre_d = '0;
                ST_RUN: begin
                    if (!pause) begin
                        if (tick) begin
                            pre_d     = '0;
                            time_d    = time_dec;
                            expired_d = dec_zero;
                        end else begin
                            pre_d = pre_q + PRE_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
        running_d = (state_d == ST_RUN);
    end

    assign time_out = time_q;
    assign state    = state_q;
    assign running  = running_q;
    assign expired  = expired_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer against a seconds-based reference model.
module tb_bcd_countdown_timer;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [23:0] load_time;
    logic        start;
    logic        pause;
    logic [23:0] time_out;
    logic [1:0]  state;
    logic        running;
    logic        expired;
    logic        load_err;

    int total = 0;
    int bad   = 0;

    // Reference model: remaining time as an integer number of seconds
    int m_secs;
    int m_ph;
    int m_st;
    bit m_exp;
    bit m_err;

    bcd_countdown_timer #(.TICK_DIV(TD), .PRE_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_time (load_time),
        .start     (start),
        .pause     (pause),
        .time_out  (time_out),
        .state     (state),
        .running   (running),
        .expired   (expired),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    function automatic int to_secs(input logic [23:0] v);
        int d[6];
        for (int i = 0; i < 6; i++) d[i] = int'(v[4*i +: 4]);
        return (d[5]*10 + d[4]) * 3600 + (d[3]*10 + d[2]) * 60 + d[1]*10 + d[0];
    endfunction

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic bit bcd_ok(input logic [23:0] v);
        int d[6];
        for (int i = 0; i < 6; i++) d[i] = int'(v[4*i +: 4]);
        for (int i = 0; i < 6; i++) if (d[i] > 9) return 1'b0;
        return (d[1] < 6) && (d[3] < 6) && (d[5]*10 + d[4] < 24);
    endfunction

    task automatic model_reset();
        m_secs = 0; m_ph = 0; m_st = 0; m_exp = 0; m_err = 0;
    endtask

    task automatic model_step(input logic l, input logic [23:0] lt, input logic s, input logic p);
        m_exp = 0;
        m_err = 0;
        if (l) begin
            if (bcd_ok(lt)) begin
                m_secs = to_secs(lt); m_st = 0; m_ph = 0;
            end else begin
                m_err = 1;
            end
        end else begin
            case (m_st)
                0: if (s && m_secs > 0) begin m_st = 1; m_ph = 0; end
                1: begin
                    if (p) m_st = 2;
                    else if (m_ph == TD - 1) begin
                        m_ph = 0;
                        m_secs--;
                        if (m_secs == 0) begin m_st = 3; m_exp = 1; end
                    end else m_ph++;
                end
                2: if (s) m_st = 1;
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".time"},     time_out,      to_bcd(m_secs));
        chk({tag, ".state"},    24'(state),    24'(m_st));
        chk({tag, ".running"},  24'(running),  24'(m_st == 1));
        chk({tag, ".expired"},  24'(expired),  24'(m_exp));
        chk({tag, ".load_err"}, 24'(load_err), 24'(m_err));
    endtask

    task automatic step(input string tag, input logic l, input logic [23:0] lt,
                        input logic s, input logic p);
        @(negedge clk);
        load = l; load_time = lt; start = s; pause = p;
        @(posedge clk);
        model_step(l, lt, s, p);
        #1;
        check_all(tag);
        load = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 24'h0, 1'b0, 1'b0);
    endtask

    task automatic do_load(input string tag, input logic [23:0] v);
        step(tag, 1'b1, v, 1'b0, 1'b0);
    endtask

    task automatic do_start(input string tag);
        step(tag, 1'b0, 24'h0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [23:0] bad_loads [4];
        rst = 1'b1; load = 1'b0; load_time = 24'h0; start = 1'b0; pause = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic countdown to expiry
        do_load("t1.load", 24'h000003);
        do_start("t1.start");
        for (int i = 1; i <= 12; i++) begin
            idle("t1.run", 1);
            if (i == 4)  chk("t1.at4",  time_out, 24'h000002);
            if (i == 8)  chk("t1.at8",  time_out, 24'h000001);
            if (i == 11) chk("t1.noexp11", 24'(expired), 24'h0);
            if (i == 12) begin
                chk("t1.at12",   time_out,      24'h000000);
                chk("t1.exp12",  24'(expired),  24'h1);
                chk("t1.done",   24'(state),    24'h3);
                chk("t1.run0",   24'(running),  24'h0);
            end
        end
        idle("t1.after", 1);
        chk("t1.exp_once", 24'(expired), 24'h0);

        // Borrow chains
        do_load("t2.l1", 24'h010000); do_start("t2.s1"); idle("t2.r1", TD);
        chk("t2.borrow_h0", time_out, 24'h005959);
        do_load("t2.l2", 24'h100000); do_start("t2.s2"); idle("t2.r2", TD);
        chk("t2.borrow_h1", time_out, 24'h095959);
        do_load("t2.l3", 24'h230000); do_start("t2.s3"); idle("t2.r3", TD);
        chk("t2.borrow_23", time_out, 24'h225959);

        // Invalid loads leave everything alone
        bad_loads[0] = 24'h000060; bad_loads[1] = 24'h006000;
        bad_loads[2] = 24'h240000; bad_loads[3] = 24'h0A0000;
        for (int i = 0; i < 4; i++) begin
            do_load("t3.bad", bad_loads[i]);
            chk("t3.err", 24'(load_err), 24'h1);
        end
        do_load("t3.good", 24'h235959);
        chk("t3.noerr", 24'(load_err), 24'h0);
        chk("t3.val",   time_out,      24'h235959);

        // Pause preserves the partial second
        do_load("t4.load", 24'h000010);
        do_start("t4.start");
        idle("t4.run", 2);
        step("t4.pause", 1'b0, 24'h0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            idle("t4.hold", 1);
            chk("t4.frozen", time_out, 24'h000010);
        end
        do_start("t4.resume");
        idle("t4.r1", 1);
        chk("t4.r1val", time_out, 24'h000010);
        idle("t4.r2", 1);
        chk("t4.r2val", time_out, 24'h000009);

        // Corners
        do_load("t5.zero", 24'h000000);
        do_start("t5.start0");
        chk("t5.idle0", 24'(state), 24'h0);
        step("t5.loadstart", 1'b1, 24'h000005, 1'b1, 1'b0);
        chk("t5.ls_state", 24'(state), 24'h0);
        chk("t5.ls_time",  time_out,   24'h000005);
        do_start("t5.go");
        idle("t5.run", 5 * TD);
        do_start("t5.startdone");
        chk("t5.stay_done", 24'(state), 24'h3);
        // load landing on the final tick wins
        do_load("t5.l1", 24'h000001); do_start("t5.s1"); idle("t5.pre", TD - 1);
        do_load("t5.race", 24'h000004);
        chk("t5.race_exp", 24'(expired), 24'h0);
        chk("t5.race_st",  24'(state),   24'h0);

        // Asynchronous reset mid-run
        do_load("t6.load", 24'h000009);
        do_start("t6.start");
        idle("t6.run", 2 * TD);
        chk("t6.at7", time_out, 24'h000007);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("t6.async");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        do_start("t6.start0");
        chk("t6.idle", 24'(state), 24'h0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic        l, s, p;
            logic [23:0] lt;
            int          sec;
            l = ($urandom_range(0, 15) == 0);
            s = ($urandom_range(0, 3) == 0);
            p = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) begin
                sec = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6))
                                                   : int'($urandom_range(0, 86399));
                lt  = to_bcd(sec);
            end else begin
                lt = 24'($urandom());
            end
            step("rnd", l, lt, s, p);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
